midi_voice_allocator: RTL and testbench
=======================================

MIDI_VOICE_ALLOCATOR -- requirements
Module: midi_voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, voices managed (legal range 2..8).
REQ-002 SHALL have parameter BYTE_W, default 8, MIDI byte width.
REQ-003 SHALL have parameter MIDI_CHAN, default 0, accepted channel 0..15.
REQ-004 SHALL have parameter OMNI, default 0; 1 = accept all channels.
REQ-005 SHALL have port sys_clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port MIDI_CMD  input  BYTE_W  last status byte from the MIDI adapter.
REQ-008 SHALL have port MIDI_DAT_0  input  BYTE_W  first data byte (note number/controller).
REQ-009 SHALL have port MIDI_DAT_1  input  BYTE_W  second data byte (velocity/value).
REQ-010 SHALL have port CMD_READY  input  1  level/pulse: MIDI_CMD valid.
REQ-011 SHALL have port DATA_READY  input  1  one-cycle pulse: data pair valid.
REQ-012 SHALL have port voice_gate  output  NUM_VOICES  per-voice gate, bit i = voice i.
REQ-013 SHALL have port voice_note  output  7*NUM_VOICES  per-voice note, voice i at [7i+6:7i].
REQ-014 SHALL have port voice_vel  output  7*NUM_VOICES  per-voice velocity, same packing.
REQ-015 SHALL have port upd_strobe  output  1  one-cycle pulse: upd_voice changed.
REQ-016 SHALL have port upd_voice  output  3  index of updated voice.
REQ-017 SHALL have port busy  output  1  high while an event is processed.
REQ-018 SHALL have port ovf  output  1  one-cycle pulse: DATA_READY dropped while busy.

Function
REQ-019 SHALL latch MIDI_CMD into a running-status register on every sys_clk edge where CMD_READY=1 and MIDI_CMD[7]=1.
REQ-020 SHALL classify events on the running status: 0x9n with DAT_1!=0 = NOTE_ON; 0x8n, or 0x9n with DAT_1=0 = NOTE_OFF; 0xBn with DAT_0=123 = ALL_OFF; all else ignored (no strobe, no state change beyond IDLE return).
REQ-021 SHALL ignore events whose channel n != MIDI_CHAN unless OMNI=1.
REQ-022 SHALL use states IDLE -> SCAN -> ACTION -> IDLE; DATA_READY in IDLE at cycle T captures status, DAT_0[6:0], DAT_1[6:0] and enters SCAN at T+1.
REQ-023 SCAN SHALL examine one voice per cycle, index 0..NUM_VOICES-1, recording first note-match among gated voices, lowest-index free voice, and oldest gated voice.
REQ-024 ACTION at T+NUM_VOICES+1 SHALL update voice registers; upd_strobe and upd_voice SHALL be valid at T+NUM_VOICES+2; busy SHALL be high T+1 through T+NUM_VOICES+2 inclusive.
REQ-025 NOTE_ON: gated voice with same note -> retrigger it (new velocity, age 0); else lowest free voice -> gate 1, note, velocity, age 0; else full-case per REQ-033/034.
REQ-026 Every NOTE_ON allocation/retrigger SHALL increment the 4-bit age of every other gated voice, saturating at 15.
REQ-027 Oldest voice SHALL be the gated voice with highest age; ties go to lowest index.
REQ-028 NOTE_OFF: matching gated voice -> gate 0, note and velocity retained, strobe; no match -> no change, no strobe.
REQ-029 ALL_OFF SHALL clear all gates and ages in ACTION with upd_strobe=1, upd_voice=0.
REQ-030 DATA_READY while busy SHALL be dropped and ovf pulsed the next cycle; in-flight event unaffected.
REQ-031 CMD_READY while busy SHALL update running status but SHALL NOT alter the captured in-flight status.
REQ-032 DATA_READY before any status since reset SHALL be ignored (status register 0x00).

Configuration
REQ-033 With VOICE_STEAL_EN defined, NOTE_ON with all voices gated SHALL steal the oldest voice: note, velocity replaced, age 0, gate stays 1, strobe.
REQ-034 Without VOICE_STEAL_EN, NOTE_ON with all voices gated SHALL be dropped: no voice change, no strobe, ages unchanged.

Reset
REQ-035 rst=1 SHALL asynchronously force: voice_gate/voice_note/voice_vel/ages 0, running status 0x00, upd_strobe 0, upd_voice 0, busy 0, ovf 0, state IDLE.
REQ-036 rst mid-SCAN/ACTION SHALL abort the event with no strobe; first event after release processed normally.

Verification
REQ-037 CMD 0x90, DATA (60,100) -> voice 0 gate 1, note 60, vel 100, upd_strobe at T+6 (NUM_VOICES=4), busy T+1..T+6.
REQ-038 Running status 0x90: (60,100),(64,90),(60,0) -> voices 0,1 allocated, then voice 0 gate 0, voice 1 still gated.
REQ-039 Five NOTE_ONs 60..64 on 4 voices -> with VOICE_STEAL_EN voice 0 becomes note 64; without it, no fifth strobe, voice 0 keeps 60.
REQ-040 DATA_READY pulsed at T and T+2 -> second dropped, ovf high at T+3, single strobe.
REQ-041 MIDI_CHAN=0, OMNI=0: CMD 0x91, (60,100) -> no strobe; then CMD 0xB0, (123,0) after two notes -> all gates 0, upd_voice 0.
REQ-042 rst asserted at T+3 of a NOTE_ON -> all outputs 0 immediately, no strobe after release.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// -----------------------------------------------------------------------------
// midi_voice_allocator
//
// Purpose:
//   Polyphonic voice allocator fed by a MIDI byte adapter. Status bytes are
//   kept in a running-status register. Each data pair is classified as
//   NOTE_ON, NOTE_OFF, ALL_OFF (CC 123) or ignored. The event then walks a
//   fixed IDLE -> SCAN -> ACTION -> IDLE sequence. SCAN visits one voice per
//   cycle, so an event always takes NUM_VOICES + 2 busy cycles.
//
// Build option:
//   VOICE_STEAL_EN - when defined, a NOTE_ON that finds every voice gated
//                    steals the oldest voice. When undefined (default), such
//                    a NOTE_ON is dropped.
//
// Parameters:
//   NUM_VOICES  voices managed (2..8)
//   BYTE_W      MIDI byte width
//   MIDI_CHAN   accepted channel (0..15)
//   OMNI        1 = accept every channel
//
// Ports:
//   sys_clk     clock, all logic on the rising edge
//   rst         asynchronous, active-high reset
//   MIDI_CMD    last status byte from the adapter
//   MIDI_DAT_0  first data byte (note number / controller)
//   MIDI_DAT_1  second data byte (velocity / value)
//   CMD_READY   MIDI_CMD valid
//   DATA_READY  one-cycle pulse, data pair valid
//   voice_gate  per-voice gate, bit i = voice i
//   voice_note  per-voice note, voice i at [7i+6:7i]
//   voice_vel   per-voice velocity, same packing
//   upd_strobe  one-cycle pulse, upd_voice changed
//   upd_voice   index of the updated voice
//   busy        high while an event is in flight
//   ovf         one-cycle pulse, a DATA_READY was dropped while busy
// -----------------------------------------------------------------------------
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int BYTE_W     = 8,
    parameter int MIDI_CHAN  = 0,
    parameter int OMNI       = 0
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [BYTE_W-1:0]       MIDI_CMD,
    input  logic [BYTE_W-1:0]       MIDI_DAT_0,
    input  logic [BYTE_W-1:0]       MIDI_DAT_1,
    input  logic                    CMD_READY,
    input  logic                    DATA_READY,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic                    upd_strobe,
    output logic [2:0]              upd_voice,
    output logic                    busy,
    output logic                    ovf
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_ACTION
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_ON,
        EV_OFF,
        EV_ALL_OFF
    } event_t;

    // FSM
    state_t r_state;
    state_t w_next_state;

    // Running status and the event captured for the current pass
    logic [BYTE_W-1:0] r_status;
    event_t            r_ev;
    logic [6:0]        r_cap_note;
    logic [6:0]        r_cap_vel;

    // Scan bookkeeping
    logic [IDX_W-1:0]  r_idx;
    logic              r_match_found;
    logic [IDX_W-1:0]  r_match_idx;
    logic              r_free_found;
    logic [IDX_W-1:0]  r_free_idx;
    logic              r_old_found;
    logic [IDX_W-1:0]  r_old_idx;
    logic [3:0]        r_old_age;

    // Voice state
    logic [NUM_VOICES-1:0] r_gate;
    logic [6:0]            r_note [NUM_VOICES];
    logic [6:0]            r_vel  [NUM_VOICES];
    logic [3:0]            r_age  [NUM_VOICES];

    // Output registers
    logic              r_strobe;
    logic [2:0]        r_upd_voice;
    logic              r_ovf;
    // Extends busy through the strobe cycle that follows ACTION
    logic              r_done;

    // Combinational helpers
    logic              w_busy;
    logic              w_accept;
    logic              w_chan_ok;
    event_t            w_event;
    logic              w_on_hit;
    logic [IDX_W-1:0]  w_on_idx;
    logic              w_unused;

    assign w_busy    = (r_state != S_IDLE) || r_done;
    assign w_accept  = DATA_READY && !w_busy;
    assign w_chan_ok = (OMNI != 0) || (r_status[3:0] == 4'(MIDI_CHAN));

    // MIDI data bytes are 7-bit; the top bit of each is never used.
`ifdef VOICE_STEAL_EN
    assign w_unused = ^{MIDI_DAT_0[BYTE_W-1:7], MIDI_DAT_1[BYTE_W-1:7]};
`else
    assign w_unused = ^{MIDI_DAT_0[BYTE_W-1:7], MIDI_DAT_1[BYTE_W-1:7], r_old_idx};
`endif

    // Event classification on the running status and the incoming pair.
    // A status of 0x00 (nothing seen since reset) has bit 7 clear, so it
    // falls through to EV_NONE.
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_event = EV_NONE;
        if (r_status[7] && w_chan_ok) begin
            case (r_status[7:4])
                4'h9:    w_event = (MIDI_DAT_1[6:0] != 7'd0) ? EV_ON : EV_OFF;
                4'h8:    w_event = EV_OFF;
                4'hB:    w_event = (MIDI_DAT_0[6:0] == 7'd123) ? EV_ALL_OFF : EV_NONE;
                default: w_event = EV_NONE;
            endcase
        end
    end

    // NOTE_ON target selection: retrigger first, then the lowest free voice,
    // then (only when stealing is built in) the oldest voice.
    always_comb begin
        w_on_hit = 1'b0;
        w_on_idx = '0;
        if (r_match_found) begin
            w_on_hit = 1'b1;
            w_on_idx = r_match_idx;
        end else if (r_free_found) begin
            w_on_hit = 1'b1;
            w_on_idx = r_free_idx;
        end
`ifdef VOICE_STEAL_EN
        else if (r_old_found) begin
            w_on_hit = 1'b1;
            w_on_idx = r_old_idx;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_SCAN;
            S_SCAN:   if (r_idx == LAST_IDX) w_next_state = S_ACTION;
            S_ACTION: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of every other.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: capture, scan, voice update, output pulses.
    // NOTE: the voice arrays sit in the reset branch because reset must
    // visibly clear every gate, note and velocity. They are a handful of
    // flops, not a RAM.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_status      <= '0;
            r_ev          <= EV_NONE;
            r_cap_note    <= '0;
            r_cap_vel     <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_gate        <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
                r_age[i]  <= '0;
            end
            r_strobe      <= 1'b0;
            r_upd_voice   <= '0;
            r_ovf         <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_ovf    <= DATA_READY && w_busy;
            r_done   <= (r_state == S_ACTION);

            // The running status may change at any time. The in-flight
            // event has its own captured copy in r_ev.
            if (CMD_READY && MIDI_CMD[7]) begin
                r_status <= MIDI_CMD;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ev          <= w_event;
                        r_cap_note    <= MIDI_DAT_0[6:0];
                        r_cap_vel     <= MIDI_DAT_1[6:0];
                        r_idx         <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_old_found   <= 1'b0;
                        r_old_age     <= '0;
                    end
                end

                S_SCAN: begin
                    if (r_gate[r_idx] && !r_match_found &&
                        (r_note[r_idx] == r_cap_note)) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!r_gate[r_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    // Strict '>' keeps the lowest index on an age tie.
                    if (r_gate[r_idx] && (!r_old_found || (r_age[r_idx] > r_old_age))) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_idx;
                        r_old_age   <= r_age[r_idx];
                    end
                    r_idx <= r_idx + 1'b1;
                end

                S_ACTION: begin
                    case (r_ev)
                        EV_ON: begin
                            if (w_on_hit) begin
                                for (int i = 0; i < NUM_VOICES; i++) begin
                                    if (IDX_W'(i) == w_on_idx) begin
                                        r_gate[i] <= 1'b1;
                                        r_note[i] <= r_cap_note;
                                        r_vel[i]  <= r_cap_vel;
                                        r_age[i]  <= '0;
                                    end else if (r_gate[i] && (r_age[i] != 4'hF)) begin
                                        r_age[i] <= r_age[i] + 4'd1;
                                    end
                                end
                                r_strobe    <= 1'b1;
                                r_upd_voice <= 3'(w_on_idx);
                            end
                        end

                        EV_OFF: begin
                            // Note and velocity are kept so a release stage
                            // downstream still knows what was playing.
                            if (r_match_found) begin
                                r_gate[r_match_idx] <= 1'b0;
                                r_strobe            <= 1'b1;
                                r_upd_voice         <= 3'(r_match_idx);
                            end
                        end

                        EV_ALL_OFF: begin
                            r_gate <= '0;
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                r_age[i] <= '0;
                            end
                            r_strobe    <= 1'b1;
                            r_upd_voice <= 3'd0;
                        end

                        default: ;
                    endcase
                end

                default: ;
            endcase
        end
    end

    // Output packing
    assign voice_gate = r_gate;
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7] = r_note[g];
        assign voice_vel[7*g +: 7]  = r_vel[g];
    end

    assign upd_strobe = r_strobe;
    assign upd_voice  = r_upd_voice;
    assign busy       = w_busy;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_midi_voice_allocator
//
// Directed stimulus for midi_voice_allocator (NUM_VOICES=4, channel 0).
// A behavioural voice model, driven by the same inputs, predicts the outputs
// for every cycle. Literal expectations at key points pin that model.
// Honours VOICE_STEAL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_midi_voice_allocator;

    localparam int NV        = 4;
    localparam int MIDI_CHAN = 0;
    localparam int OMNI      = 0;

    logic              sys_clk = 1'b0;
    logic              rst     = 1'b1;
    logic [7:0]        MIDI_CMD   = '0;
    logic [7:0]        MIDI_DAT_0 = '0;
    logic [7:0]        MIDI_DAT_1 = '0;
    logic              CMD_READY  = 1'b0;
    logic              DATA_READY = 1'b0;
    logic [NV-1:0]     voice_gate;
    logic [7*NV-1:0]   voice_note;
    logic [7*NV-1:0]   voice_vel;
    logic              upd_strobe;
    logic [2:0]        upd_voice;
    logic              busy;
    logic              ovf;

    always #5 sys_clk = ~sys_clk;

    midi_voice_allocator #(
        .NUM_VOICES (NV),
        .BYTE_W     (8),
        .MIDI_CHAN  (MIDI_CHAN),
        .OMNI       (OMNI)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .MIDI_CMD   (MIDI_CMD),
        .MIDI_DAT_0 (MIDI_DAT_0),
        .MIDI_DAT_1 (MIDI_DAT_1),
        .CMD_READY  (CMD_READY),
        .DATA_READY (DATA_READY),
        .voice_gate (voice_gate),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .upd_strobe (upd_strobe),
        .upd_voice  (upd_voice),
        .busy       (busy),
        .ovf        (ovf)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Voice table as plain ints. An accepted event is resolved at once into a
    // pending table that becomes visible NV+1 edges later, together with the
    // strobe. busy stays visible for NV+2 cycles after the accepting edge.
    bit m_gate [NV];
    int m_note [NV];
    int m_vel  [NV];
    int m_age  [NV];
    bit p_gate [NV];
    int p_note [NV];
    int p_vel  [NV];
    int p_age  [NV];
    bit p_strobe;
    int p_idx;
    int m_status;
    int busy_cnt;
    int pend_cnt;
    bit exp_strobe;
    bit exp_ovf;
    int exp_upd;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
        m_status = 0; busy_cnt = 0; pend_cnt = 0;
        exp_strobe = 0; exp_ovf = 0; exp_upd = 0; p_strobe = 0; p_idx = 0;
    endtask

    task automatic model_event(input int st, input int d0, input int d1);
        int kind;   // 0 ignore, 1 on, 2 off, 3 all-off
        int tgt;
        p_gate = m_gate; p_note = m_note; p_vel = m_vel; p_age = m_age;
        p_strobe = 0;
        kind = 0;
        if (st >= 128 && (OMNI != 0 || (st % 16) == MIDI_CHAN)) begin
            if (st / 16 == 9)                     kind = (d1 != 0) ? 1 : 2;
            else if (st / 16 == 8)                kind = 2;
            else if (st / 16 == 11 && d0 == 123)  kind = 3;
        end
        tgt = -1;
        if (kind == 1 || kind == 2)
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_gate[i] && m_note[i] == d0) tgt = i;
        if (kind == 1) begin
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_gate[i]) tgt = i;
`ifdef VOICE_STEAL_EN
            if (tgt < 0) begin
                int best;
                best = 0;
                for (int i = 1; i < NV; i++)
                    if (m_age[i] > m_age[best]) best = i;
                tgt = best;
            end
`endif
            if (tgt >= 0) begin
                for (int i = 0; i < NV; i++)
                    if (i != tgt && m_gate[i]) p_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
                p_gate[tgt] = 1; p_note[tgt] = d0; p_vel[tgt] = d1; p_age[tgt] = 0;
                p_strobe = 1; p_idx = tgt;
            end
        end else if (kind == 2) begin
            if (tgt >= 0) begin
                p_gate[tgt] = 0; p_strobe = 1; p_idx = tgt;
            end
        end else if (kind == 3) begin
            for (int i = 0; i < NV; i++) begin
                p_gate[i] = 0; p_age[i] = 0;
            end
            p_strobe = 1; p_idx = 0;
        end
    endtask

    task automatic model_step();
        bit was_busy;
        was_busy   = (busy_cnt > 0);
        exp_ovf    = DATA_READY && was_busy;
        exp_strobe = 0;
        if (busy_cnt > 0) busy_cnt--;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                m_gate = p_gate; m_note = p_note; m_vel = p_vel; m_age = p_age;
                exp_strobe = p_strobe;
                if (p_strobe) exp_upd = p_idx;
            end
        end
        if (DATA_READY && !was_busy) begin
            model_event(m_status, int'(MIDI_DAT_0[6:0]), int'(MIDI_DAT_1[6:0]));
            busy_cnt = NV + 2;
            pend_cnt = NV + 1;
        end
        if (CMD_READY && MIDI_CMD[7]) m_status = int'(MIDI_CMD);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // -------------------------------------------------------------- compare
    bit              mon_en = 0;
    int              strobe_total = 0;
    logic [NV-1:0]   eg;
    logic [7*NV-1:0] en;
    logic [7*NV-1:0] ev;

    initial forever begin
        @(negedge sys_clk);
        if (mon_en && !rst) begin
            for (int i = 0; i < NV; i++) begin
                eg[i]       = m_gate[i];
                en[7*i +: 7] = 7'(m_note[i]);
                ev[7*i +: 7] = 7'(m_vel[i]);
            end
            check("gate",   voice_gate, eg);
            check("note",   voice_note, en);
            check("vel",    voice_vel,  ev);
            check("busy",   busy,       busy_cnt > 0);
            check("strobe", upd_strobe, exp_strobe);
            check("ovf",    ovf,        exp_ovf);
            if (exp_strobe) check("upd_voice", upd_voice, 3'(exp_upd));
            if (upd_strobe) strobe_total++;
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic send_cmd(input logic [7:0] b);
        @(negedge sys_clk); MIDI_CMD = b; CMD_READY = 1'b1;
        @(negedge sys_clk); CMD_READY = 1'b0;
    endtask

    task automatic pulse_data(input int d0, input int d1);
        @(negedge sys_clk);
        MIDI_DAT_0 = 8'(d0); MIDI_DAT_1 = 8'(d1); DATA_READY = 1'b1;
        @(negedge sys_clk);
        DATA_READY = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge sys_clk);
            k++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic send_ev(input int d0, input int d1);
        pulse_data(d0, d1);
        wait_idle();
    endtask

    // Records, relative to the DATA_READY cycle T, the first and last busy
    // cycle, the strobe cycle and upd_voice at the strobe.
    int s_at, b_first, b_last, s_upd, base;
    task automatic timed_ev(input int d0, input int d1);
        s_at = -1; b_first = -1; b_last = -1; s_upd = -1;
        pulse_data(d0, d1);
        for (int k = 1; k <= 12; k++) begin
            if (busy) begin
                if (b_first < 0) b_first = k;
                b_last = k;
            end
            if (upd_strobe && s_at < 0) begin
                s_at  = k;
                s_upd = int'(upd_voice);
            end
            @(negedge sys_clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_gate",   voice_gate, '0);
        check("rst_note",   voice_note, '0);
        check("rst_vel",    voice_vel,  '0);
        check("rst_strobe", upd_strobe, 1'b0);
        check("rst_upd",    upd_voice,  3'd0);
        check("rst_busy",   busy,       1'b0);
        check("rst_ovf",    ovf,        1'b0);
        rst = 1'b0; mon_en = 1;

        // Data before any status is ignored.
        base = strobe_total;
        send_ev(60, 100);
        check("no_status_strobes", strobe_total - base, 0);

        // First NOTE_ON: timing and voice 0 contents.
        send_cmd(8'h90);
        timed_ev(60, 100);
        check("on_strobe_cycle", s_at,    6);
        check("on_busy_first",   b_first, 1);
        check("on_busy_last",    b_last,  6);
        check("on_upd_voice",    s_upd,   0);
        check("on_v0_note",      voice_note[6:0], 7'd60);
        check("on_v0_vel",       voice_vel[6:0],  7'd100);
        check("on_gate",         voice_gate, 4'b0001);

        // Running status: second note, then velocity-0 release.
        send_ev(64, 90);
        check("two_gates", voice_gate, 4'b0011);
        send_ev(60, 0);
        check("vel0_off_gate", voice_gate, 4'b0010);
        check("off_keeps_note", voice_note[6:0], 7'd60);

        // Retrigger of a sounding note updates only its velocity.
        send_ev(64, 50);
        check("retrig_vel",  voice_vel[13:7], 7'd50);
        check("retrig_gate", voice_gate, 4'b0010);

        // 0x8n release of a note that is not sounding: no strobe.
        base = strobe_total;
        send_cmd(8'h80);
        send_ev(70, 0);
        check("off_nomatch_strobes", strobe_total - base, 0);

        // Wrong channel is ignored; ALL_OFF after two notes.
        base = strobe_total;
        send_cmd(8'h91);
        send_ev(61, 100);
        check("chan_filter_strobes", strobe_total - base, 0);
        send_cmd(8'h90);
        send_ev(60, 100);
        send_ev(62, 100);
        check("pre_alloff_gate", voice_gate, 4'b0111);
        send_cmd(8'hB0);
        timed_ev(123, 0);
        check("alloff_gate", voice_gate, 4'b0000);
        check("alloff_upd",  s_upd, 0);

        // Five NOTE_ONs on four voices.
        base = strobe_total;
        send_cmd(8'h90);
        for (int n = 60; n <= 64; n++) send_ev(n, 100);
`ifdef VOICE_STEAL_EN
        check("fifth_strobes", strobe_total - base, 5);
        check("steal_v0_note", voice_note[6:0], 7'd64);
`else
        check("fifth_strobes", strobe_total - base, 4);
        check("drop_v0_note",  voice_note[6:0], 7'd60);
`endif

        // Overlapping DATA_READY: second one dropped, ovf at T+3.
        send_cmd(8'hB0);
        send_ev(123, 0);
        send_cmd(8'h90);
        base = strobe_total;
        @(negedge sys_clk); MIDI_DAT_0 = 8'd60; MIDI_DAT_1 = 8'd100; DATA_READY = 1'b1;
        @(negedge sys_clk); DATA_READY = 1'b0;
        @(negedge sys_clk); MIDI_DAT_0 = 8'd61; DATA_READY = 1'b1;
        @(negedge sys_clk); DATA_READY = 1'b0;
        check("ovf_at_t3", ovf, 1'b1);
        wait_idle();
        check("ovf_single_strobe", strobe_total - base, 1);
        check("ovf_gate", voice_gate, 4'b0001);

        // Status change while busy does not touch the in-flight event.
        @(negedge sys_clk); MIDI_DAT_0 = 8'd65; MIDI_DAT_1 = 8'd100; DATA_READY = 1'b1;
        @(negedge sys_clk); DATA_READY = 1'b0;
        @(negedge sys_clk); MIDI_CMD = 8'h80; CMD_READY = 1'b1;
        @(negedge sys_clk); CMD_READY = 1'b0;
        wait_idle();
        check("inflight_kept_on", voice_gate, 4'b0011);
        send_ev(65, 40);
        check("new_status_off", voice_gate, 4'b0001);

        // Age saturation decides the steal victim.
        send_cmd(8'hB0);
        send_ev(123, 0);
        send_cmd(8'h90);
        send_ev(70, 100);
        send_ev(71, 100);
        for (int r = 0; r < 14; r++) send_ev(71, 80 + r);
        send_ev(72, 100);
        send_ev(73, 100);
        send_ev(74, 100);
`ifdef VOICE_STEAL_EN
        check("sat_victim_v0", voice_note[6:0], 7'd74);
`else
        check("sat_full_drop", voice_note[6:0], 7'd70);
`endif

        // Reset in the middle of an event.
        base = strobe_total;
        @(negedge sys_clk); MIDI_DAT_0 = 8'd80; MIDI_DAT_1 = 8'd100; DATA_READY = 1'b1;
        @(negedge sys_clk); DATA_READY = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk); rst = 1'b1;
        #1;
        check("midrst_gate",   voice_gate, '0);
        check("midrst_note",   voice_note, '0);
        check("midrst_vel",    voice_vel,  '0);
        check("midrst_busy",   busy,       1'b0);
        check("midrst_strobe", upd_strobe, 1'b0);
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        repeat (12) @(negedge sys_clk);
        check("midrst_no_strobe", strobe_total - base, 0);
        send_cmd(8'h90);
        send_ev(80, 100);
        check("post_rst_strobe", strobe_total - base, 1);
        check("post_rst_gate",   voice_gate, 4'b0001);
        check("post_rst_note",   voice_note[6:0], 7'd80);

        repeat (3) @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
